// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT read scheduler: FSM states, error codes,
// frame byte-field positions and the frame checksum helper.
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_CHECK,
    ST_FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ENGINE  = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int RH_INT_MSB = 39;
  localparam int RH_DEC_MSB = 31;
  localparam int T_INT_MSB  = 23;
  localparam int T_DEC_MSB  = 15;
  localparam int CSUM_MSB   = 7;

  // 8-bit wrap-around sum of the four data bytes.
  function automatic logic [7:0] frame_csum(input logic [39:0] f);
    frame_csum = f[RH_INT_MSB -: 8] + f[RH_DEC_MSB -: 8] + f[T_INT_MSB -: 8] + f[T_DEC_MSB -: 8];
  endfunction

endpackage

// File: rtl/dht_ms_tick.sv
// Free-running 1 ms strobe: one-cycle tick_o every CLK_HZ/1000 clock cycles.
module dht_ms_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht_poll_scheduler.sv
// DHT read scheduler: merges button/auto requests, enforces the inter-read holdoff,
// supervises the engine with a timeout and checksum check. Optional retry: DHT_RETRY_EN.
import dht_pkg::*;

module dht_poll_scheduler #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int MIN_INTERVAL_MS = 2000,
  parameter int AUTO_PERIOD_MS  = 5000,
  parameter int TIMEOUT_MS      = 30,
  parameter int MAX_RETRY       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        auto_en_i,
  output logic        start_o,
  output logic        abort_o,
  input  logic        eng_done_i,
  input  logic        eng_err_i,
  input  logic [39:0] eng_data_i,
  output logic [15:0] hum_o,
  output logic [15:0] temp_o,
  output logic        valid_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  localparam int HW = $clog2(MIN_INTERVAL_MS + 1);
  localparam int AW = $clog2(AUTO_PERIOD_MS + 1);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam logic [HW-1:0] HO_MAX    = HW'(MIN_INTERVAL_MS);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD_MS - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_MS);

  logic tick;

  dht_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          ho_skip_q, ho_skip_d;
  logic [AW-1:0] auto_q, auto_d;
  logic [TW-1:0] to_q, to_d;
  logic          to_skip_q, to_skip_d;
  logic [39:0]   frame_q, frame_d;
  logic [15:0]   hum_q, hum_d;
  logic [15:0]   temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [1:0]    code_q, code_d;
  logic          auto_fire;
  logic          fail_ev;
  logic [1:0]    fail_code;

`ifdef DHT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
  logic          ext_q, ext_d;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    holdoff_d = holdoff_q;
    ho_skip_d = ho_skip_q;
    auto_d    = auto_q;
    to_d      = to_q;
    to_skip_d = to_skip_q;
    frame_d   = frame_q;
    hum_d     = hum_q;
    temp_d    = temp_q;
    valid_d   = valid_q;
    error_d   = error_q;
    code_d    = code_q;
    start_o   = 1'b0;
    abort_o   = 1'b0;
    auto_fire = 1'b0;
    fail_ev   = 1'b0;
    fail_code = ERR_NONE;
`ifdef DHT_RETRY_EN
    retry_d   = retry_q;
    ext_d     = ext_q;
`endif

    if (!auto_en_i) begin
      auto_d = '0;
    end else if (tick) begin
      if (auto_q == AUTO_LAST) begin
        auto_d    = '0;
        auto_fire = 1'b1;
      end else begin
        auto_d = auto_q + 1'b1;
      end
    end

    // The first tick after a clear is partial, so it only arms the count;
    // that keeps holdoff and timeout from ever coming out short.
    if (tick && (holdoff_q != HO_MAX)) begin
      if (ho_skip_q) ho_skip_d = 1'b0;
      else           holdoff_d = holdoff_q + 1'b1;
    end

    if ((state_q == ST_WAIT_DONE) && tick && (to_q != TO_MAX)) begin
      if (to_skip_q) to_skip_d = 1'b0;
      else           to_d      = to_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q && (holdoff_q == HO_MAX)) state_d = ST_START;
      end
      ST_START: begin
        start_o   = 1'b1;
        to_d      = '0;
        to_skip_d = 1'b1;
        holdoff_d = '0;
        ho_skip_d = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (eng_err_i) begin
          fail_ev   = 1'b1;
          fail_code = ERR_ENGINE;
          state_d   = ST_FAIL;
        end else if (eng_done_i) begin
          frame_d = eng_data_i;
          state_d = ST_CHECK;
        end else if (to_q == TO_MAX) begin
          abort_o   = 1'b1;
          fail_ev   = 1'b1;
          fail_code = ERR_TIMEOUT;
          state_d   = ST_FAIL;
        end
      end
      ST_CHECK: begin
        if (frame_csum(frame_q) == frame_q[CSUM_MSB -: 8]) begin
          hum_d   = frame_q[RH_INT_MSB -: 16];
          temp_d  = frame_q[T_INT_MSB -: 16];
          valid_d = 1'b1;
          error_d = 1'b0;
          code_d  = ERR_NONE;
`ifdef DHT_RETRY_EN
          retry_d = '0;
`endif
          state_d = ST_IDLE;
        end else begin
          fail_ev   = 1'b1;
          fail_code = ERR_CSUM;
          state_d   = ST_FAIL;
        end
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_o) pending_d = 1'b0;
    if (req_i || auto_fire) pending_d = 1'b1;

`ifdef DHT_RETRY_EN
    if (start_o) ext_d = 1'b0;
    if (req_i || auto_fire) ext_d = 1'b1;
    // A fresh request starts a new attempt sequence with the full retry budget.
    if ((state_q == ST_IDLE) && (state_d == ST_START) && ext_q) retry_d = '0;
    if (fail_ev) begin
      if (retry_q < RETRY_MAX) begin
        retry_d   = retry_q + 1'b1;
        pending_d = 1'b1;
      end else begin
        retry_d = '0;
        error_d = 1'b1;
        code_d  = fail_code;
      end
    end
`else
    if (fail_ev) begin
      error_d = 1'b1;
      code_d  = fail_code;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      holdoff_q <= HO_MAX;
      ho_skip_q <= 1'b0;
      auto_q    <= '0;
      to_q      <= '0;
      to_skip_q <= 1'b0;
      frame_q   <= '0;
      hum_q     <= '0;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      holdoff_q <= holdoff_d;
      ho_skip_q <= ho_skip_d;
      auto_q    <= auto_d;
      to_q      <= to_d;
      to_skip_q <= to_skip_d;
      frame_q   <= frame_d;
      hum_q     <= hum_d;
      temp_q    <= temp_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      code_q    <= code_d;
    end
  end

`ifdef DHT_RETRY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q <= '0;
      ext_q   <= 1'b0;
    end else begin
      retry_q <= retry_d;
      ext_q   <= ext_d;
    end
  end
`endif

  assign hum_o      = hum_q;
  assign temp_o     = temp_q;
  assign valid_o    = valid_q;
  assign error_o    = error_q;
  assign err_code_o = code_q;
  assign busy_o     = (state_q == ST_START) || (state_q == ST_WAIT_DONE) || (state_q == ST_CHECK);

endmodule
